gpr_commit_file: RTL
====================

Name: gpr_commit_file

Overview:
- 32 x XLEN RISC-V integer register file for the NPC core, with retire-gated writes.
- Feeds the GPR trace/DPI stage downstream through a flattened snapshot of all registers, plus a one-entry commit record (pc, rd, wdata) held under a valid/ready handshake.
- Decode reads rs1/rs2 from it; writeback retires into it.

Parameters:
- XLEN, 64, register width.
- NREG, 32, register count; index width = $clog2(NREG).
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns the new wdata.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_addr  in  5  read port 1 index.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_addr  in  5  read port 2 index.
- rs2_data  out  XLEN  read port 2 data, combinational.
- commit_valid  in  1  writeback stage presents a retiring instruction.
- commit_ready  out  1  block can accept a retire this cycle.
- commit_pc  in  XLEN  pc of the retiring instruction.
- commit_wen  in  1  retiring instruction writes rd.
- commit_rd  in  5  destination index.
- commit_wdata  in  XLEN  destination data.
- trace_valid  out  1  commit record pending for the trace consumer.
- trace_ready  in  1  trace consumer takes the record.
- trace_pc  out  XLEN  pc of the pending record.
- trace_rd  out  5  rd of the pending record; 0 if no write.
- trace_wdata  out  XLEN  data written; 0 if no write.
- trace_regs  out  NREG*XLEN  flattened live register state; slice i = x[i]; feeds the trace stage's per-register inputs.
- retire_count  out  64  number of accepted retires since reset.

Behaviour:
- Reset (synchronous, highest priority): all x[i] = 0, trace_valid = 0, trace_pc/trace_rd/trace_wdata = 0, retire_count = 0. Reset clears a pending record and wins over a same-cycle accept.
- accept = commit_valid & commit_ready.
- commit_ready = !trace_valid | trace_ready, combinational.
- Upstream holds commit_* stable while commit_valid & !commit_ready.
- Register write: on accept & commit_wen & (commit_rd != 0), x[commit_rd] <= commit_wdata on the next edge.
- Writes are gated by accept only. No write happens on a stalled commit.
- x0 always reads 0. A write to rd = 0 is discarded.
- Reads are combinational: rsN_data = (rsN_addr == 0) ? 0 : x[rsN_addr].
- With BYPASS = 1, if accept & commit_wen & commit_rd == rsN_addr & rsN_addr != 0, then rsN_data = commit_wdata.
- With BYPASS = 0, the old value is read until the next edge.
- Commit record is loaded on accept, valid the cycle after:
  - trace_valid <= 1;
  - trace_pc <= commit_pc;
  - trace_rd <= commit_wen ? commit_rd : 0;
  - trace_wdata <= (commit_wen & commit_rd != 0) ? commit_wdata : 0.
- trace_regs is registered state. When trace_valid rises, trace_regs already includes that commit's write, so difftest compares post-retire state.
- Handshake cases:
  - trace_valid & trace_ready & !accept -> trace_valid <= 0.
  - trace_valid & trace_ready & accept (same-cycle replace) -> record overwritten, trace_valid stays 1, no bubble.
  - trace_valid & !trace_ready -> commit_ready = 0 and the record is held unchanged.
- retire_count increments by 1 per accept and wraps at 2^64 - 1 -> 0.
- No other internal state. Two-state FSM on trace_valid: EMPTY, FULL.
  - EMPTY -accept-> FULL.
  - FULL -ready & !accept-> EMPTY.
  - FULL -ready & accept-> FULL.
  - FULL -!ready-> FULL.

Decomposition:
- Shared package npc_pkg holds: XLEN, NREG, REG_AW = 5, and a commit_rec_t struct {pc, rd, wdata}.
- One sub-module gpr_array holds the storage, 2 combinational read ports, 1 write port, x0 hardwire and the bypass mux.
- The top level holds the handshake FSM, the record register and retire_count.

Test Plan:
- Reset then read all 32 registers -> every rs1_data/rs2_data = 0, trace_valid = 0, retire_count = 0.
- Retire pc=0x80000000, rd=5, wdata=0xDEAD_BEEF, trace_ready=1 -> next cycle trace_valid=1, trace_rd=5, trace_regs slice 5 = 0xDEADBEEF, retire_count=1. Then read rs1=5 returns 0xDEADBEEF.
- Retire rd=0, wdata=0x1234 -> x0 reads 0, trace_rd=0, trace_wdata=0, retire_count increments.
- BYPASS=1: same-cycle retire rd=7, wdata=0x55, with rs2_addr=7 -> rs2_data=0x55 combinationally.
- trace_ready=0 with a record pending, then present a retire rd=3, wdata=9 -> commit_ready=0 and x3 unchanged. Raise trace_ready -> accept in that cycle, record replaced, trace_valid stays 1, x3=9 next cycle.
- Assert reset while trace_valid=1 and commit_valid=1 -> next cycle all outputs back to reset values and no register written.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: register-file geometry, commit record layout
// and the trace-handshake state encoding.
package npc_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } commit_rec_t;

    typedef enum logic {
        TRACE_EMPTY = 1'b0,
        TRACE_FULL  = 1'b1
    } trace_state_e;

    // A retire only touches the array when it is accepted, writes, and targets a real register.
    function automatic logic gpr_write_en(input logic accept, input logic wen,
                                          input logic [REG_AW-1:0] rd);
        return accept & wen & (rd != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/gpr_commit_file_if.sv
// Retire (writeback -> register file) and trace (register file -> trace stage)
// handshakes bundled together; slave is the register-file side.
interface gpr_commit_file_if #(
    parameter int XLEN   = npc_pkg::XLEN,
    parameter int REG_AW = npc_pkg::REG_AW
);
    logic              commit_valid;
    logic              commit_ready;
    logic [XLEN-1:0]   commit_pc;
    logic              commit_wen;
    logic [REG_AW-1:0] commit_rd;
    logic [XLEN-1:0]   commit_wdata;

    logic              trace_valid;
    logic              trace_ready;
    logic [XLEN-1:0]   trace_pc;
    logic [REG_AW-1:0] trace_rd;
    logic [XLEN-1:0]   trace_wdata;

    modport master (
        output commit_valid, commit_pc, commit_wen, commit_rd, commit_wdata, trace_ready,
        input  commit_ready, trace_valid, trace_pc, trace_rd, trace_wdata
    );

    modport slave (
        input  commit_valid, commit_pc, commit_wen, commit_rd, commit_wdata, trace_ready,
        output commit_ready, trace_valid, trace_pc, trace_rd, trace_wdata
    );
endinterface

// File: rtl/gpr_array.sv
// Integer register storage: two combinational read ports, one write port,
// x0 hardwired to zero and an optional write-to-read bypass.
module gpr_array #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AW-1:0]        rs1_addr_i,
    output logic [XLEN-1:0]      rs1_data_o,
    input  logic [AW-1:0]        rs2_addr_i,
    output logic [XLEN-1:0]      rs2_data_o,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [XLEN-1:0]      wdata_i,
    output logic [NREG*XLEN-1:0] regs_o
);

    logic [XLEN-1:0] mem_q [NREG];

    // Storage update; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != {AW{1'b0}})) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q[waddr_i] <= mem_q[waddr_i];
        end
    end

    // Read port 1 with x0 hardwire and optional same-cycle forwarding.
    always_comb begin
        rs1_data_o = mem_q[rs1_addr_i];
        if (rs1_addr_i == {AW{1'b0}}) begin
            rs1_data_o = '0;
        end else if ((BYPASS != 0) && we_i && (waddr_i == rs1_addr_i)) begin
            rs1_data_o = wdata_i;
        end else begin
            rs1_data_o = mem_q[rs1_addr_i];
        end
    end

    // Read port 2, identical structure to port 1.
    always_comb begin
        rs2_data_o = mem_q[rs2_addr_i];
        if (rs2_addr_i == {AW{1'b0}}) begin
            rs2_data_o = '0;
        end else if ((BYPASS != 0) && we_i && (waddr_i == rs2_addr_i)) begin
            rs2_data_o = wdata_i;
        end else begin
            rs2_data_o = mem_q[rs2_addr_i];
        end
    end

    // Snapshot shows the committed state only; no forwarding here.
    for (genvar g = 0; g < NREG; g++) begin : g_snap
        if (g == 0) begin : g_zero
            assign regs_o[g*XLEN +: XLEN] = '0;
        end else begin : g_reg
            assign regs_o[g*XLEN +: XLEN] = mem_q[g];
        end
    end

endmodule

// File: rtl/gpr_commit_file.sv
// Retire-gated register file with a one-entry commit record for the trace
// stage and a free-running retire counter.
module gpr_commit_file #(
    parameter int XLEN   = npc_pkg::XLEN,
    parameter int NREG   = npc_pkg::NREG,
    parameter int BYPASS = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [npc_pkg::REG_AW-1:0] rs1_addr,
    output logic [XLEN-1:0]            rs1_data,
    input  logic [npc_pkg::REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]            rs2_data,
    gpr_commit_file_if.slave           bus,
    output logic [NREG*XLEN-1:0]       trace_regs,
    output logic [63:0]                retire_count
);
    import npc_pkg::*;

    trace_state_e state_q, state_d;
    commit_rec_t  rec_q, rec_d;
    logic [63:0]  count_q, count_d;
    logic         ready_s;
    logic         accept_s;
    logic         wr_en_s;

    assign wr_en_s = gpr_write_en(accept_s, bus.commit_wen, bus.commit_rd);

    gpr_array #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .AW     (REG_AW),
        .BYPASS (BYPASS)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .rs1_addr_i (rs1_addr),
        .rs1_data_o (rs1_data),
        .rs2_addr_i (rs2_addr),
        .rs2_data_o (rs2_data),
        .we_i       (wr_en_s),
        .waddr_i    (bus.commit_rd),
        .wdata_i    (bus.commit_wdata),
        .regs_o     (trace_regs)
    );

    // State, record and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TRACE_EMPTY;
            rec_q   <= '0;
            count_q <= 64'd0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: a same-cycle take-and-refill keeps the slot full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACE_EMPTY: begin
                if (accept_s) state_d = TRACE_FULL;
                else          state_d = TRACE_EMPTY;
            end
            TRACE_FULL: begin
                if (bus.trace_ready && !accept_s) state_d = TRACE_EMPTY;
                else                              state_d = TRACE_FULL;
            end
            default: state_d = TRACE_EMPTY;
        endcase
    end

    // Handshake outputs derived from the current state.
    always_comb begin
        ready_s  = (state_q == TRACE_EMPTY) | bus.trace_ready;
        accept_s = bus.commit_valid & ready_s;
        bus.commit_ready = ready_s;
        bus.trace_valid  = (state_q == TRACE_FULL);
    end

    // Record and counter next values; rd/wdata report zero when nothing was written.
    always_comb begin
        rec_d   = rec_q;
        count_d = count_q;
        if (accept_s) begin
            rec_d.pc    = bus.commit_pc;
            rec_d.rd    = bus.commit_wen ? bus.commit_rd : {REG_AW{1'b0}};
            rec_d.wdata = wr_en_s ? bus.commit_wdata : {XLEN{1'b0}};
            count_d     = count_q + 64'd1;
        end else begin
            rec_d   = rec_q;
            count_d = count_q;
        end
    end

    assign bus.trace_pc    = rec_q.pc;
    assign bus.trace_rd    = rec_q.rd;
    assign bus.trace_wdata = rec_q.wdata;
    assign retire_count    = count_q;

endmodule
